pror_decoder_seq: RTL

//  Sequenced binary-to-one-hot decoder; consumes the (a,v) code stream our priority encoder produces.

---
 rtl/pror_decoder_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pror_decoder_seq.sv
// Sequenced binary-to-one-hot decoder: buffers (a,v) codes in a FIFO and replays each one
// as a PULSE_LEN-cycle one-hot strobe on y, followed by GAP_LEN idle cycles.
module pror_decoder_seq #(
    parameter int unsigned IW        = 2,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PULSE_LEN = 3,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IW-1:0]              a,
    input  logic                       v,
    output logic                       in_ready,
    output logic [(1<<IW)-1:0]         y,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned YW     = 1 << IW;
    localparam int unsigned LW     = $clog2(DEPTH + 1);
    localparam int unsigned PW     = $clog2(DEPTH);
    localparam int unsigned CntMax = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1;

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [YW-1:0]    y_q, y_d;
    logic             done_q, done_d;
    logic [LW-1:0]    level_q, level_d;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [IW-1:0]    mem_q [DEPTH];
    logic [IW-1:0]    mem_d [DEPTH];
    logic             push, pop;

    // in_ready looks only at the registered level, so a same-cycle pop never frees a slot
    assign in_ready = !rst && (level_q < LW'(DEPTH));
    assign push     = v && in_ready;
    assign pop      = (state_q == StIdle) && (level_q != '0);

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (push) begin
            mem_d[wr_q] = a;
            wr_d        = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                y_d = '0;
                if (pop) begin
                    y_d     = YW'(1) << mem_q[rd_q];
                    cnt_d   = CW'(PULSE_LEN - 1);
                    state_d = StPulse;
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    y_d     = '0;
                    done_d  = 1'b1;
                    cnt_d   = CW'(GAP_LEN - 1);
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StGap: begin
                y_d = '0;
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                y_d     = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            level_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            done_q  <= done_d;
            level_q <= level_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by level_q and the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign y     = y_q;
    assign done  = done_q;
    assign busy  = (state_q != StIdle);
    assign level = level_q;

endmodule
